// File: rtl/smg_scan_paramod.sv
// Multiplexed common-anode 7-segment scanner: DIGITS digits, per-slot dead time, per-digit dp,
// frame-shadowed data with an oFrame strobe. Define SMG_LZB_EN for leading-zero blanking.
module smg_scan_paramod #(
  parameter int DIGITS       = 6,
  parameter int SCAN_CYCLES  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                  CLOCK,
  input  logic                  RESET,
  input  logic [4*DIGITS-1:0]   iData,
  input  logic [DIGITS-1:0]     iDP,
  output logic [7:0]            DIG,
  output logic [DIGITS-1:0]     SEL,
  output logic                  oFrame
);

  localparam int CW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] C1_LAST = CW'(SCAN_CYCLES - 1);
  localparam logic [IW-1:0] I_LAST  = IW'(DIGITS - 1);

  logic [CW-1:0]         r_c1;
  logic [IW-1:0]         r_idx;
  logic [4*DIGITS-1:0]   r_shadow;
  logic [DIGITS-1:0]     r_shadow_dp;

  logic                  w_c1_wrap;
  logic                  w_load;
  logic                  w_dead;
  logic [3:0]            w_nibs [DIGITS];
  logic [DIGITS-1:0]     w_lz;
  logic [3:0]            w_nib;
  logic [6:0]            w_seg;

  function automatic logic [6:0] f_encode(input logic [3:0] nib);
    case (nib)
      4'h0: f_encode = 7'h40;
      4'h1: f_encode = 7'h79;
      4'h2: f_encode = 7'h24;
      4'h3: f_encode = 7'h30;
      4'h4: f_encode = 7'h19;
      4'h5: f_encode = 7'h12;
      4'h6: f_encode = 7'h02;
      4'h7: f_encode = 7'h78;
      4'h8: f_encode = 7'h00;
      4'h9: f_encode = 7'h10;
      4'hA: f_encode = 7'h08;
      4'hB: f_encode = 7'h03;
      4'hC: f_encode = 7'h46;
      4'hD: f_encode = 7'h21;
      4'hE: f_encode = 7'h06;
      default: f_encode = 7'h0E;
    endcase
  endfunction

  assign w_c1_wrap = (r_c1 == C1_LAST);
  assign w_load    = w_c1_wrap && (r_idx == I_LAST);

  generate
    if (BLANK_CYCLES == 0) begin : g_no_dead
      assign w_dead = 1'b0;
    end else begin : g_dead
      assign w_dead = (r_c1 < CW'(BLANK_CYCLES));
    end
  endgenerate

  // w_lz[k]: nibble k and every more-significant nibble are zero; digit 0 never qualifies
  genvar k;
  generate
    for (k = 0; k < DIGITS; k++) begin : g_nib
      assign w_nibs[k] = r_shadow[4*k +: 4];
      if (k == 0) begin : g_lsd
        assign w_lz[k] = 1'b0;
      end else begin : g_msd
        assign w_lz[k] = ~|r_shadow[4*DIGITS-1:4*k];
      end
    end
  endgenerate

  assign w_nib = w_nibs[r_idx];

`ifdef SMG_LZB_EN
  assign w_seg = w_lz[r_idx] ? 7'h7F : f_encode(w_nib);
`else
  assign w_seg = f_encode(w_nib);
`endif

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      r_c1        <= '0;
      r_idx       <= '0;
      r_shadow    <= '0;
      r_shadow_dp <= '0;
      SEL         <= '1;
      DIG         <= 8'hFF;
      oFrame      <= 1'b0;
    end else begin
      r_c1 <= w_c1_wrap ? '0 : r_c1 + 1'b1;
      if (w_c1_wrap) begin
        r_idx <= (r_idx == I_LAST) ? '0 : r_idx + 1'b1;
      end
      // Capture coincides with the digit wrap so digit 0 of the next frame sees new data
      if (w_load) begin
        r_shadow    <= iData;
        r_shadow_dp <= iDP;
      end
      oFrame <= w_load;
      if (w_dead) begin
        SEL <= '1;
        DIG <= 8'hFF;
      end else begin
        SEL <= ~(DIGITS'(1) << r_idx);
        DIG <= {~r_shadow_dp[r_idx], w_seg};
      end
    end
  end

  // unused when leading-zero blanking is compiled out
  logic w_unused_lz;
  assign w_unused_lz = ^w_lz;

endmodule

// File: tb/tb_smg_scan_paramod.sv
// Randomised bench for smg_scan_paramod (DIGITS=4, SCAN_CYCLES=8) against a frame-level model,
// with a second instance using BLANK_CYCLES=0.
module tb_smg_scan_paramod;
  localparam int D = 4;
  localparam int S = 8;
  localparam int B = 2;
  localparam int F = D * S;

  logic        CLOCK = 1'b0;
  logic        RESET = 1'b1;
  logic [15:0] iData = 16'h0;
  logic [3:0]  iDP   = 4'h0;
  logic [7:0]  DIG, DIG0;
  logic [3:0]  SEL, SEL0;
  logic        oFrame, oFrame0;

  always #5 CLOCK = ~CLOCK;

  smg_scan_paramod #(.DIGITS(D), .SCAN_CYCLES(S), .BLANK_CYCLES(B)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .iData(iData), .iDP(iDP),
    .DIG(DIG), .SEL(SEL), .oFrame(oFrame));

  smg_scan_paramod #(.DIGITS(D), .SCAN_CYCLES(S), .BLANK_CYCLES(0)) dut0 (
    .CLOCK(CLOCK), .RESET(RESET), .iData(iData), .iDP(iDP),
    .DIG(DIG0), .SEL(SEL0), .oFrame(oFrame0));

  int n_chk = 0;
  int n_fail = 0;

  // model: m_t = clocks since reset release; outputs after an edge reflect time m_t-1
  int          m_t = 0;
  logic [15:0] m_sh = 16'h0;
  logic [3:0]  m_dp = 4'h0;
  logic [3:0]  e_sel = 4'hF, e_sel0 = 4'hF;
  logic [7:0]  e_dig = 8'hFF, e_dig0 = 8'hFF;
  logic        e_fr = 1'b0;

  function automatic logic [6:0] seg(input logic [3:0] n);
    logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return tbl[n];
  endfunction

  function automatic logic [11:0] expect_out(input int t, input int blank,
                                             input logic [15:0] sh, input logic [3:0] dp);
    int c, d;
    logic [3:0] nib;
    logic [6:0] s7;
    logic [15:0] upper;
    c = t % S;
    d = (t / S) % D;
    if (c < blank) return {4'hF, 8'hFF};
    upper = sh >> (4 * d);
    nib = upper[3:0];
    s7 = seg(nib);
`ifdef SMG_LZB_EN
    if (d >= 1 && upper == 16'h0) s7 = 7'h7F;
`endif
    return {~(4'b0001 << d), ~dp[d], s7};
  endfunction

  always @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      m_t = 0; m_sh = 16'h0; m_dp = 4'h0;
      e_sel = 4'hF; e_dig = 8'hFF; e_sel0 = 4'hF; e_dig0 = 8'hFF; e_fr = 1'b0;
    end else begin
      {e_sel, e_dig}   = expect_out(m_t, B, m_sh, m_dp);
      {e_sel0, e_dig0} = expect_out(m_t, 0, m_sh, m_dp);
      e_fr = (m_t % F == F - 1);
      if (e_fr) begin
        m_sh = iData;
        m_dp = iDP;
      end
      m_t++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0d, time %0t)", name, act, exp, m_t, $time);
    end
  endtask

  always @(negedge CLOCK) begin
    chk("sel", 32'(SEL), 32'(e_sel));
    chk("dig", 32'(DIG), 32'(e_dig));
    chk("frame", 32'(oFrame), 32'(e_fr));
    chk("sel_nb", 32'(SEL0), 32'(e_sel0));
    chk("dig_nb", 32'(DIG0), 32'(e_dig0));
    chk("frame_nb", 32'(oFrame0), 32'(e_fr));
    if (RESET && m_t > 0) chk("sel_nb_never_idle", 32'(SEL0 == 4'hF), 32'd0);
  end

  // wait (bounded) until the outputs show counter time s
  task automatic at_state(input int s);
    for (int n = 0; n < 400; n++) begin
      @(negedge CLOCK);
      if (m_t == s + 1) return;
    end
    n_fail++;
    $display("FAIL wait_state: never reached t=%0d (now %0d)", s, m_t);
  endtask

  task automatic lit(input string name, input logic [3:0] s_exp, input logic [7:0] d_exp);
    chk({name, "_sel"}, 32'(SEL), 32'(s_exp));
    chk({name, "_dig"}, 32'(DIG), 32'(d_exp));
  endtask

  initial begin
    logic [7:0] lz_ff;
`ifdef SMG_LZB_EN
    lz_ff = 8'hFF;
`else
    lz_ff = 8'hC0;
`endif
    #1 RESET = 1'b0;
    iData = 16'h1234;
    repeat (3) @(negedge CLOCK);
    lit("reset", 4'hF, 8'hFF);
    chk("reset_frame", 32'(oFrame), 32'd0);
    RESET = 1'b1;

    at_state(4);   lit("f1_d0", 4'hE, 8'hC0);
    at_state(27);  lit("f1_d3", 4'h7, lz_ff);
    at_state(30);  chk("frame_pre", 32'(oFrame), 32'd0);
    at_state(31);  chk("frame_first", 32'(oFrame), 32'd1);
    at_state(32);  lit("f2_dead", 4'hF, 8'hFF);
    chk("frame_once", 32'(oFrame), 32'd0);
    at_state(35);  lit("f2_d0", 4'hE, 8'h99);
    at_state(43);  lit("f2_d1", 4'hD, 8'hB0);
    at_state(51);  lit("f2_d2", 4'hB, 8'hA4);
    at_state(59);  lit("f2_d3", 4'h7, 8'hF9);
    at_state(63);  chk("frame_second", 32'(oFrame), 32'd1);

    at_state(76);  iData = 16'hABCD;
    at_state(84);  lit("tear_d2", 4'hB, 8'hA4);
    at_state(92);  lit("tear_d3", 4'h7, 8'hF9);
    at_state(100); lit("f4_d0", 4'hE, 8'hA1);
    at_state(124); lit("f4_d3", 4'h7, 8'h88);
    iData = 16'h1234; iDP = 4'b0010;
    at_state(132); lit("dp_d0", 4'hE, 8'h99);
    at_state(140); lit("dp_d1", 4'hD, 8'h30);

    for (int n = 0; n < 24; n++) begin
      repeat ($urandom_range(1, 40)) @(negedge CLOCK);
      iData = 16'($urandom);
      iDP   = 4'($urandom);
      if ($urandom_range(0, 3) == 0) iData[15:8] = 8'h00;
    end

    // asynchronous reset in slot 2 at C1=5
    begin
      int n;
      for (n = 0; n < 64 && (m_t % F) != 21; n++) @(negedge CLOCK);
      if ((m_t % F) != 21) begin
        n_fail++;
        $display("FAIL async_align: could not reach slot 2 C1=5");
      end
    end
    #2 RESET = 1'b0;
    #1 lit("async_rst", 4'hF, 8'hFF);
    chk("async_rst_frame", 32'(oFrame), 32'd0);
    chk("async_rst_sel_nb", 32'(SEL0), 32'hF);
    iData = 16'h0050; iDP = 4'h0;
    repeat (2) @(negedge CLOCK);
    RESET = 1'b1;

    at_state(3);   lit("rr_d0", 4'hE, 8'hC0);
    at_state(27);  lit("rr_d3", 4'h7, lz_ff);
    at_state(35);  lit("lz_d0", 4'hE, 8'hC0);
    at_state(43);  lit("lz_d1", 4'hD, 8'h92);
    at_state(51);  lit("lz_d2", 4'hB, lz_ff);
    at_state(59);  lit("lz_d3", 4'h7, lz_ff);
    iData = 16'h0000;
    at_state(67);  lit("zero_d0", 4'hE, 8'hC0);
    at_state(75);  lit("zero_d1", 4'hD, lz_ff);
    at_state(96);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/smg_scan_paramod.md
Name: smg_scan_paramod

Overview:
Parametrised multiplexed 7-segment scan controller. It is the next generation of the fixed 6-digit hex display path and supersedes the funcmod-plus-encoder pair.
- Drives DIGITS common-anode digits from a packed hex word.
- Anti-ghosting dead time at the start of every digit slot.
- Per-digit decimal point.
- Tear-free frame shadowing.
- Emits a frame strobe for upstream data producers.

Parameters:
DIGITS, 6, number of digits / SEL width; legal range 1..8.
SCAN_CYCLES, 50000, clocks per digit slot (1 ms at 50 MHz); must be > BLANK_CYCLES.
BLANK_CYCLES, 500, dead-time clocks at the start of each slot; 0 disables dead time.

Ports:
CLOCK  in  1  system clock.
RESET  in  1  asynchronous, active-low reset.
iData  in  4*DIGITS  hex nibbles; nibble k (iData[4k+3:4k]) is shown on digit k; digit 0 is least significant.
iDP  in  DIGITS  decimal-point request per digit; 1 = lit.
DIG  out  8  segment drive, active-low; DIG[7] is dp, DIG[6:0] are g..a.
SEL  out  DIGITS  digit select, active-low one-hot.
oFrame  out  1  one-clock pulse when the shadow registers load.

Behaviour:
Counters:
- C1 counts 0..SCAN_CYCLES-1 and wraps.
- Digit index i increments when C1 wraps; it wraps DIGITS-1 -> 0.

Shadow load:
- In the cycle where C1==SCAN_CYCLES-1 and i==DIGITS-1, iData/iDP are captured into shadow registers.
- oFrame is registered high for the next clock only.
- iData/iDP are never used directly; changes mid-frame are invisible until the next frame.

Outputs:
- SEL/DIG are registered from the current C1, i and shadow values, so they lag the counters by exactly 1 clock.
- Dead time (C1 < BLANK_CYCLES): SEL = all ones, DIG = 8'hFF.
- Active (C1 >= BLANK_CYCLES): SEL = ~(1<<i); DIG[6:0] = encode(shadow nibble i); DIG[7] = ~shadowDP[i].

Encode table (DIG[6:0] shown with DIG[7]=1):
- 0:C0 1:F9 2:A4 3:B0 4:99 5:92 6:82 7:F8
- 8:80 9:90 A:88 B:83 C:C6 D:A1 E:86 F:8E

Reset (RESET low, asynchronous, any time, including mid-slot):
- C1=0, i=0, shadow=0, shadowDP=0.
- SEL = all ones, DIG = 8'hFF, oFrame = 0.

After reset release:
- Scanning restarts at digit 0, slot start.
- The first frame displays all "0" with no dp.
- The first oFrame occurs DIGITS*SCAN_CYCLES clocks after release.

Simultaneous events: the shadow load and the i wrap occur in the same cycle. Digit 0 of the new frame uses the new shadow.

No handshake on iData; producers use oFrame to time updates.

Optional Feature:
SMG_LZB_EN (leading-zero blanking).
- Defined: digit k (k >= 1) is blanked (DIG[6:0]=7F) when shadow nibble k and all more-significant nibbles are 0. DIG[7] still follows shadowDP[k], and SEL is still asserted in its slot. Digit 0 is never blanked.
- Undefined: all digits always show their encoded nibble.

Test Plan:
Bench parameters: DIGITS=4, SCAN_CYCLES=8, BLANK_CYCLES=2.
1. Reset: RESET low -> SEL=4'hF, DIG=FF, oFrame=0. Assert RESET in slot 2 at C1=5 -> outputs return to F/FF immediately without waiting for a clock. Release -> scan resumes at digit 0.
2. Scan: iData=16'h1234, iDP=0. In the second frame, per slot (2 clocks F/FF, then 6 clocks): digit 0 SEL=1110 DIG=99; digit 1 SEL=1101 DIG=B0; digit 2 SEL=1011 DIG=A4; digit 3 SEL=0111 DIG=F9. oFrame pulses once every 32 clocks.
3. Tear-free: change iData to 16'hABCD in the middle of digit 1 -> the rest of the frame still shows 1234. The next frame shows digit 0 DIG=A1, digit 3 DIG=88.
4. DP: iData=16'h1234, iDP=4'b0010 -> digit 1 DIG=30; the other digits are unchanged.
5. LZB with macro: iData=16'h0050 -> digits 3 and 2 DIG=FF, digit 1 DIG=92, digit 0 DIG=C0. iData=16'h0000 -> only digit 0 shows C0. Without the macro, digit 3 DIG=C0.
6. BLANK_CYCLES=0 -> SEL is never all ones after reset release, and each digit is active for 8 consecutive clocks.
